// File: rtl/tile_map_writer_pkg.sv
// Shared types and defaults for the tile map writer.
// The 80 px tile on a 640x480 screen gives an 8x6 grid.
package tile_pkg;
  localparam int TILE_PX   = 80;
  localparam int COLS      = 640 / TILE_PX;
  localparam int ROWS      = 480 / TILE_PX;
  localparam int TYPE_W    = 2;
  localparam int NUM_TILES = COLS * ROWS;
  localparam int IDX_W     = 6;  // sweep index width
  localparam int XY_W      = 3;  // column/row coordinate width

  typedef logic [TYPE_W-1:0] tile_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } wr_state_t;
endpackage

// File: rtl/tile_map_writer_if.sv
// Game-logic/renderer side bus of the tile map writer.
// Optional macro TILE_OOB_ERR_EN adds oob_err / oob_cnt status.
interface tile_map_writer_if #(
  parameter int TYPE_W = tile_pkg::TYPE_W,
  parameter int XY_W   = tile_pkg::XY_W
);
  logic              wr_valid;
  logic              wr_ready;
  logic [XY_W-1:0]   wr_x;
  logic [XY_W-1:0]   wr_y;
  logic [TYPE_W-1:0] wr_type;
  logic              clr_req;
  logic [TYPE_W-1:0] clr_type;
  logic              clr_done;
  logic              busy;
  logic [XY_W-1:0]   rd_x;
  logic [XY_W-1:0]   rd_y;
  logic [TYPE_W-1:0] rd_type;
`ifdef TILE_OOB_ERR_EN
  logic              oob_err;
  logic [7:0]        oob_cnt;
`endif

  modport slave (
    input  wr_valid, wr_x, wr_y, wr_type, clr_req, clr_type, rd_x, rd_y,
    output wr_ready, clr_done, busy, rd_type
`ifdef TILE_OOB_ERR_EN
    , output oob_err, oob_cnt
`endif
  );

  modport master (
    output wr_valid, wr_x, wr_y, wr_type, clr_req, clr_type, rd_x, rd_y,
    input  wr_ready, clr_done, busy, rd_type
`ifdef TILE_OOB_ERR_EN
    , input oob_err, oob_cnt
`endif
  );
endinterface

// File: rtl/tile_map_writer_clear_fsm.sv
// Clear-sweep sequencer: walks every cell in row-major order writing the
// latched fill value, then pulses clr_done for one cycle.
module tile_clear_fsm #(
  parameter int COLS   = tile_pkg::COLS,
  parameter int ROWS   = tile_pkg::ROWS,
  parameter int TYPE_W = tile_pkg::TYPE_W,
  parameter int IDX_W  = tile_pkg::IDX_W,
  parameter int XY_W   = tile_pkg::XY_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req_i,
  input  logic [TYPE_W-1:0] clr_type_i,
  output logic              idle_o,
  output logic              busy_o,
  output logic              clr_done_o,
  output logic              sweep_we_o,
  output logic [XY_W-1:0]   sweep_x_o,
  output logic [XY_W-1:0]   sweep_y_o,
  output logic [TYPE_W-1:0] sweep_val_o
);
  import tile_pkg::*;

  localparam int              NTILES   = COLS * ROWS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NTILES - 1);
  localparam logic [IDX_W-1:0] COLS_I   = IDX_W'(COLS);

  wr_state_t         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TYPE_W-1:0] fill_q, fill_d;

  // State, sweep index and fill value registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fill_q  <= fill_d;
    end
  end

  // Next state: a new clr_req is only honoured from IDLE, so a request
  // arriving mid-sweep cannot restart it.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fill_d  = fill_q;
    unique case (state_q)
      IDLE: begin
        if (clr_req_i) begin
          state_d = CLEAR;
          fill_d  = clr_type_i;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign idle_o      = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign clr_done_o  = (state_q == DONE);
  assign sweep_we_o  = (state_q == CLEAR);
  // Constant divide/modulo keeps non-power-of-2 COLS correct.
  assign sweep_x_o   = XY_W'(idx_q % COLS_I);
  assign sweep_y_o   = XY_W'(idx_q / COLS_I);
  assign sweep_val_o = fill_q;
endmodule

// File: rtl/tile_map_writer.sv
// Tile map writer: COLS x ROWS grid of tile types with a valid/ready
// single-tile write port, a bulk clear sweep and a 1-cycle read port.
// Optional macro TILE_OOB_ERR_EN adds sticky oob_err and saturating oob_cnt.
module tile_map_writer #(
  parameter int COLS   = tile_pkg::COLS,
  parameter int ROWS   = tile_pkg::ROWS,
  parameter int TYPE_W = tile_pkg::TYPE_W
) (
  input logic              clk,
  input logic              reset,
  tile_map_writer_if.slave bus
);
  import tile_pkg::*;

  localparam int               XW     = tile_pkg::XY_W;
  localparam logic [XW:0]      COLS_B = (XW + 1)'(COLS);
  localparam logic [XW:0]      ROWS_B = (XW + 1)'(ROWS);

  logic [TYPE_W-1:0] grid_q [ROWS][COLS];
  logic [TYPE_W-1:0] rd_type_q;

  logic              fsm_idle;
  logic              sweep_we;
  logic [XW-1:0]     sweep_x, sweep_y;
  logic [TYPE_W-1:0] sweep_val;
  logic              wr_ready, wr_fire, wr_inb, rd_inb;

  tile_clear_fsm #(
    .COLS(COLS), .ROWS(ROWS), .TYPE_W(TYPE_W), .IDX_W(IDX_W), .XY_W(XW)
  ) u_clear_fsm (
    .clk        (clk),
    .reset      (reset),
    .clr_req_i  (bus.clr_req),
    .clr_type_i (bus.clr_type),
    .idle_o     (fsm_idle),
    .busy_o     (bus.busy),
    .clr_done_o (bus.clr_done),
    .sweep_we_o (sweep_we),
    .sweep_x_o  (sweep_x),
    .sweep_y_o  (sweep_y),
    .sweep_val_o(sweep_val)
  );

  // A clear request on the same cycle as a write takes precedence: the
  // write is back-pressured and must be held by the master.
  assign wr_ready     = !reset && fsm_idle && !bus.clr_req;
  assign bus.wr_ready = wr_ready;
  assign wr_fire      = bus.wr_valid && wr_ready;
  assign wr_inb       = ({1'b0, bus.wr_x} < COLS_B) && ({1'b0, bus.wr_y} < ROWS_B);
  assign rd_inb       = ({1'b0, bus.rd_x} < COLS_B) && ({1'b0, bus.rd_y} < ROWS_B);

  // Grid storage: sweep and single writes never overlap since wr_ready is
  // low outside IDLE; out-of-bounds writes complete but change nothing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          grid_q[r][c] <= '0;
    end else if (sweep_we) begin
      grid_q[sweep_y][sweep_x] <= sweep_val;
    end else if (wr_fire && wr_inb) begin
      grid_q[bus.wr_y][bus.wr_x] <= bus.wr_type;
    end
  end

  // Registered read: samples pre-write contents, so a same-cycle write to
  // the read cell shows up on the following read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       rd_type_q <= '0;
    else if (rd_inb) rd_type_q <= grid_q[bus.rd_y][bus.rd_x];
    else             rd_type_q <= '0;
  end

  assign bus.rd_type = rd_type_q;

`ifdef TILE_OOB_ERR_EN
  logic       oob_err_q;
  logic [7:0] oob_cnt_q;
  logic       clr_go;

  assign clr_go = bus.clr_req && fsm_idle;

  // Out-of-bounds status: cleared by an accepted clear, counter saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oob_err_q <= 1'b0;
      oob_cnt_q <= '0;
    end else if (clr_go) begin
      oob_err_q <= 1'b0;
      oob_cnt_q <= '0;
    end else if (wr_fire && !wr_inb) begin
      oob_err_q <= 1'b1;
      if (oob_cnt_q != 8'hFF) oob_cnt_q <= oob_cnt_q + 8'd1;
    end
  end

  assign bus.oob_err = oob_err_q;
  assign bus.oob_cnt = oob_cnt_q;
`endif
endmodule

// File: tb/tb_tile_map_writer.sv
// Scoreboard bench for tile_map_writer: read expectations come from a
// bench-side grid model and are queued when a read is issued.
module tb_tile_map_writer;
  import tile_pkg::*;

  localparam int C = 8;
  localparam int R = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tile_map_writer_if bus ();

  tile_map_writer dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int    checks = 0;
  int    errors = 0;
  tile_t mdl [R][C];
  tile_t exp_q [$];

  initial begin
    #200000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mdl_fill(input tile_t v);
    for (int y = 0; y < R; y++)
      for (int x = 0; x < C; x++)
        mdl[y][x] = v;
  endtask

  // Drives one write and holds it until accepted; updates the model.
  task automatic do_write(input int x, input int y, input tile_t t);
    int n;
    n = 0;
    bus.wr_x = 3'(x); bus.wr_y = 3'(y); bus.wr_type = t; bus.wr_valid = 1'b1;
    #1;
    while (!bus.wr_ready && n < 100) begin tick(); n++; end
    if (!bus.wr_ready) begin
      checks++; errors++;
      $display("FAIL write_timeout (%0d,%0d) got wr_ready %0b exp 1", x, y, bus.wr_ready);
    end
    tick();
    bus.wr_valid = 1'b0;
    if (x < C && y < R) mdl[y][x] = t;
  endtask

  task automatic test_reset();
    tile_t e;
    reset = 1'b1;
    bus.wr_valid = 0; bus.wr_x = 0; bus.wr_y = 0; bus.wr_type = 0;
    bus.clr_req = 0; bus.clr_type = 0; bus.rd_x = 0; bus.rd_y = 0;
    mdl_fill(2'd0);
    tick(); tick();
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL rst_wr_ready got %0b exp 0", bus.wr_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", bus.busy); end
    checks++; if (bus.clr_done !== 1'b0) begin errors++; $display("FAIL rst_clr_done got %0b exp 0", bus.clr_done); end
    checks++; if (bus.rd_type !== 2'd0) begin errors++; $display("FAIL rst_rd_type got %0d exp 0", bus.rd_type); end
`ifdef TILE_OOB_ERR_EN
    checks++; if (bus.oob_cnt !== 8'd0 || bus.oob_err !== 1'b0) begin errors++; $display("FAIL rst_oob got %0d/%0b exp 0/0", bus.oob_cnt, bus.oob_err); end
`endif
    reset = 1'b0;
    #1;
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL rst_release_wr_ready got %0b exp 1", bus.wr_ready); end
    tick();
    for (int y = 0; y < R; y++)
      for (int x = 0; x < C; x++) begin
        bus.rd_x = 3'(x); bus.rd_y = 3'(y); exp_q.push_back(mdl[y][x]); tick();
        e = exp_q.pop_front(); checks++;
        if (bus.rd_type !== e) begin errors++; $display("FAIL rst_cell(%0d,%0d) got %0d exp %0d", x, y, bus.rd_type, e); end
      end
  endtask

  task automatic test_write_read();
    tile_t e;
    do_write(3, 2, 2'd2);
    for (int y = 0; y < R; y++)
      for (int x = 0; x < C; x++) begin
        bus.rd_x = 3'(x); bus.rd_y = 3'(y); exp_q.push_back(mdl[y][x]); tick();
        e = exp_q.pop_front(); checks++;
        if (bus.rd_type !== e) begin errors++; $display("FAIL wr_cell(%0d,%0d) got %0d exp %0d", x, y, bus.rd_type, e); end
      end
  endtask

  task automatic test_same_cycle_rw();
    tile_t e;
    bus.wr_x = 3'd1; bus.wr_y = 3'd1; bus.wr_type = 2'd2; bus.wr_valid = 1'b1;
    bus.rd_x = 3'd1; bus.rd_y = 3'd1;
    #1;
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL rw_wr_ready got %0b exp 1", bus.wr_ready); end
    exp_q.push_back(mdl[1][1]);
    tick();
    bus.wr_valid = 1'b0;
    e = exp_q.pop_front(); checks++;
    if (bus.rd_type !== e) begin errors++; $display("FAIL rw_old got %0d exp %0d", bus.rd_type, e); end
    mdl[1][1] = 2'd2;
    exp_q.push_back(mdl[1][1]);
    tick();
    e = exp_q.pop_front(); checks++;
    if (bus.rd_type !== e) begin errors++; $display("FAIL rw_new got %0d exp %0d", bus.rd_type, e); end
  endtask

  task automatic test_clear();
    tile_t e;
    int n, dn, dat, bad;
    bus.clr_type = 2'd1; bus.clr_req = 1'b1;
    #1;
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL clr_req_wr_ready got %0b exp 0", bus.wr_ready); end
    tick();
    bus.clr_req = 1'b0;
    n = 0; dn = 0; dat = 0; bad = 0;
    while (bus.busy && n < 100) begin
      n++;
      if (bus.clr_done) begin dn++; dat = n; end
      if (bus.wr_ready) bad++;
      tick();
    end
    checks++; if (n != 49) begin errors++; $display("FAIL clr_busy_cycles got %0d exp 49", n); end
    checks++; if (dn != 1) begin errors++; $display("FAIL clr_done_count got %0d exp 1", dn); end
    checks++; if (dat != 49) begin errors++; $display("FAIL clr_done_cycle got %0d exp 49", dat); end
    checks++; if (bad != 0) begin errors++; $display("FAIL clr_wr_ready_high got %0d exp 0", bad); end
    checks++; if (bus.clr_done !== 1'b0) begin errors++; $display("FAIL clr_done_after got %0b exp 0", bus.clr_done); end
    mdl_fill(2'd1);
    for (int y = 0; y < R; y++)
      for (int x = 0; x < C; x++) begin
        bus.rd_x = 3'(x); bus.rd_y = 3'(y); exp_q.push_back(mdl[y][x]); tick();
        e = exp_q.pop_front(); checks++;
        if (bus.rd_type !== e) begin errors++; $display("FAIL clr_cell(%0d,%0d) got %0d exp %0d", x, y, bus.rd_type, e); end
      end
  endtask

  task automatic test_clr_wr_collision();
    tile_t e;
    int n;
    bit saw;
    bus.wr_x = 3'd5; bus.wr_y = 3'd5; bus.wr_type = 2'd3; bus.wr_valid = 1'b1;
    bus.clr_type = 2'd2; bus.clr_req = 1'b1;
    #1;
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL col_wr_ready got %0b exp 0", bus.wr_ready); end
    tick();
    bus.clr_req = 1'b0;
    n = 0; saw = 0;
    while (!bus.wr_ready && n < 100) begin
      if (bus.clr_done) saw = 1;
      tick(); n++;
    end
    checks++; if (n != 49) begin errors++; $display("FAIL col_wait_cycles got %0d exp 49", n); end
    checks++; if (saw != 1'b1) begin errors++; $display("FAIL col_saw_done got %0b exp 1", saw); end
    tick();
    bus.wr_valid = 1'b0;
    mdl_fill(2'd2);
    mdl[5][5] = 2'd3;
    for (int y = 0; y < R; y++)
      for (int x = 0; x < C; x++) begin
        bus.rd_x = 3'(x); bus.rd_y = 3'(y); exp_q.push_back(mdl[y][x]); tick();
        e = exp_q.pop_front(); checks++;
        if (bus.rd_type !== e) begin errors++; $display("FAIL col_cell(%0d,%0d) got %0d exp %0d", x, y, bus.rd_type, e); end
      end
  endtask

  // wr_x is 3 bits, so with COLS=8 no column is out of range; the two
  // out-of-bounds writes use rows 6 and 7 instead.
  task automatic test_oob();
    tile_t e;
    int n;
    do_write(0, 6, 2'd3);
    do_write(2, 7, 2'd3);
`ifdef TILE_OOB_ERR_EN
    checks++; if (bus.oob_cnt !== 8'd2) begin errors++; $display("FAIL oob_cnt got %0d exp 2", bus.oob_cnt); end
    checks++; if (bus.oob_err !== 1'b1) begin errors++; $display("FAIL oob_err got %0b exp 1", bus.oob_err); end
`endif
    bus.rd_x = 3'd3; bus.rd_y = 3'd7; exp_q.push_back(2'd0); tick();
    e = exp_q.pop_front(); checks++;
    if (bus.rd_type !== e) begin errors++; $display("FAIL oob_read got %0d exp %0d", bus.rd_type, e); end
    for (int y = 0; y < R; y++)
      for (int x = 0; x < C; x++) begin
        bus.rd_x = 3'(x); bus.rd_y = 3'(y); exp_q.push_back(mdl[y][x]); tick();
        e = exp_q.pop_front(); checks++;
        if (bus.rd_type !== e) begin errors++; $display("FAIL oob_cell(%0d,%0d) got %0d exp %0d", x, y, bus.rd_type, e); end
      end
    bus.clr_type = 2'd0; bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
`ifdef TILE_OOB_ERR_EN
    checks++; if (bus.oob_cnt !== 8'd0 || bus.oob_err !== 1'b0) begin errors++; $display("FAIL oob_clear got %0d/%0b exp 0/0", bus.oob_cnt, bus.oob_err); end
`endif
    n = 0;
    while (bus.busy && n < 100) begin tick(); n++; end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL oob_sweep_end got busy %0b exp 0", bus.busy); end
    mdl_fill(2'd0);
  endtask

  task automatic test_reset_mid_sweep();
    tile_t e;
    int dn;
    bus.clr_type = 2'd3; bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    repeat (19) tick();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %0b exp 1", bus.busy); end
    reset = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy_reset got %0b exp 0", bus.busy); end
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL mid_wr_ready_reset got %0b exp 0", bus.wr_ready); end
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL mid_wr_ready_release got %0b exp 1", bus.wr_ready); end
    dn = 0;
    repeat (60) begin
      if (bus.clr_done || bus.busy) dn++;
      tick();
    end
    checks++; if (dn != 0) begin errors++; $display("FAIL mid_no_done got %0d exp 0", dn); end
    mdl_fill(2'd0);
    for (int y = 0; y < R; y++)
      for (int x = 0; x < C; x++) begin
        bus.rd_x = 3'(x); bus.rd_y = 3'(y); exp_q.push_back(mdl[y][x]); tick();
        e = exp_q.pop_front(); checks++;
        if (bus.rd_type !== e) begin errors++; $display("FAIL mid_cell(%0d,%0d) got %0d exp %0d", x, y, bus.rd_type, e); end
      end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_same_cycle_rw();
    test_clear();
    test_clr_wr_collision();
    test_oob();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
